// File: rtl/slave_rx_deframe.sv
// rtl/slave_rx_deframe.sv - slave link receive deframer: header parse, word/sample reassembly, ack and error count
// Optional FRAME_TIMEOUT_EN adds an inter-byte gap timeout of TIMEOUT_CYCLES.
module slave_rx_deframe #(
  parameter real         TCQ            = 0.1,
  parameter logic [15:0] CMD_READBACK   = 16'h0001,
  parameter logic [15:0] CMD_RAW_ADC    = 16'h0002,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slave_rx_byte_num_en_i,
  input  logic [15:0] slave_rx_byte_num_i,
  input  logic        slave_rx_byte_en_i,
  input  logic [7:0]  slave_rx_byte_i,
  output logic        slave_rx_ack_o,
  output logic        readback_vld_o,
  output logic        readback_last_o,
  output logic [31:0] readback_data_o,
  output logic        raw_adc_vld_o,
  output logic [15:0] raw_adc_data_o,
  output logic        frame_err_o,
  output logic [7:0]  frame_err_cnt_o
);

  typedef enum logic [2:0] {IDLE, CMD_HI, CMD_LO, PAYLOAD, DISCARD} state_t;

  state_t      state;
  logic [15:0] remaining;
  logic [7:0]  cmd_hi;
  logic        is_adc;
  logic [1:0]  elem_cnt;
  logic [31:0] acc;

  logic [15:0] rem_dec;
  logic [31:0] acc_next;
  logic [15:0] cmd_word;
  logic        elem_done;
  logic        cmd_known;
  logic        timeout;

  assign rem_dec   = remaining - 16'd1;
  assign acc_next  = {acc[23:0], slave_rx_byte_i};
  assign cmd_word  = {cmd_hi, slave_rx_byte_i};
  assign elem_done = is_adc ? (elem_cnt == 2'd1) : (elem_cnt == 2'd3);
  assign cmd_known = (cmd_word == CMD_READBACK) || (cmd_word == CMD_RAW_ADC);

`ifdef FRAME_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [GAP_W-1:0] gap_cnt;

  assign timeout = (state != IDLE) && !slave_rx_byte_en_i && !slave_rx_byte_num_en_i &&
                   (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_cnt <= '0;
    end else if (state == IDLE || slave_rx_byte_en_i || slave_rx_byte_num_en_i || timeout) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      remaining       <= '0;
      cmd_hi          <= '0;
      is_adc          <= 1'b0;
      elem_cnt        <= '0;
      acc             <= '0;
      slave_rx_ack_o  <= 1'b0;
      readback_vld_o  <= 1'b0;
      readback_last_o <= 1'b0;
      readback_data_o <= '0;
      raw_adc_vld_o   <= 1'b0;
      raw_adc_data_o  <= '0;
      frame_err_o     <= 1'b0;
      frame_err_cnt_o <= '0;
    end else begin
      slave_rx_ack_o  <= 1'b0;
      readback_vld_o  <= 1'b0;
      readback_last_o <= 1'b0;
      raw_adc_vld_o   <= 1'b0;
      frame_err_o     <= 1'b0;

      // Count trails the error pulse by one cycle so it can be taken from the registered strobe
      if (frame_err_o && frame_err_cnt_o != 8'hFF) begin
        frame_err_cnt_o <= frame_err_cnt_o + 8'd1;
      end

      if (slave_rx_byte_num_en_i) begin
        // Frame start wins over any byte in the same cycle; a start mid-frame aborts it
        remaining <= slave_rx_byte_num_i;
        elem_cnt  <= '0;
        acc       <= '0;
        if (state != IDLE || slave_rx_byte_num_i < 16'd2) begin
          frame_err_o <= 1'b1;
        end
        state <= (slave_rx_byte_num_i < 16'd2) ? IDLE : CMD_HI;
      end else if (timeout) begin
        frame_err_o <= 1'b1;
        elem_cnt    <= '0;
        state       <= IDLE;
      end else if (slave_rx_byte_en_i) begin
        case (state)
          IDLE: begin
          end
          CMD_HI: begin
            cmd_hi    <= slave_rx_byte_i;
            remaining <= rem_dec;
            state     <= CMD_LO;
          end
          CMD_LO: begin
            remaining <= rem_dec;
            elem_cnt  <= '0;
            is_adc    <= (cmd_word == CMD_RAW_ADC);
            if (rem_dec == 16'd0) begin
              slave_rx_ack_o <= cmd_known;
              frame_err_o    <= !cmd_known;
              state          <= IDLE;
            end else begin
              state <= cmd_known ? PAYLOAD : DISCARD;
            end
          end
          PAYLOAD: begin
            remaining <= rem_dec;
            acc       <= acc_next;
            if (elem_done) begin
              elem_cnt <= '0;
              if (is_adc) begin
                raw_adc_vld_o  <= 1'b1;
                raw_adc_data_o <= acc_next[15:0];
              end else begin
                readback_vld_o  <= 1'b1;
                readback_data_o <= acc_next;
                // Fewer than four bytes left means no further whole word can follow
                readback_last_o <= (rem_dec < 16'd4);
              end
            end else begin
              elem_cnt <= elem_cnt + 2'd1;
            end
            if (rem_dec == 16'd0) begin
              state          <= IDLE;
              slave_rx_ack_o <= elem_done;
              frame_err_o    <= !elem_done;
            end
          end
          DISCARD: begin
            remaining <= rem_dec;
            if (rem_dec == 16'd0) begin
              frame_err_o <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slave_rx_deframe.sv
// tb/tb_slave_rx_deframe.sv - scoreboard bench for slave_rx_deframe
module tb_slave_rx_deframe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        num_en = 1'b0;
  logic [15:0] num = '0;
  logic        byte_en = 1'b0;
  logic [7:0]  byte_d = '0;
  logic        ack, rb_vld, rb_last, adc_vld, err;
  logic [31:0] rb_data;
  logic [15:0] adc_data;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  slave_rx_deframe #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .slave_rx_byte_num_en_i (num_en),
    .slave_rx_byte_num_i    (num),
    .slave_rx_byte_en_i     (byte_en),
    .slave_rx_byte_i        (byte_d),
    .slave_rx_ack_o         (ack),
    .readback_vld_o         (rb_vld),
    .readback_last_o        (rb_last),
    .readback_data_o        (rb_data),
    .raw_adc_vld_o          (adc_vld),
    .raw_adc_data_o         (adc_data),
    .frame_err_o            (err),
    .frame_err_cnt_o        (err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_rb[$];
  logic [15:0] exp_adc[$];
  logic [7:0]  fb[$];
  logic [32:0] rb_e;
  logic [15:0] adc_e;
  int ack_seen = 0, err_seen = 0, exp_ack = 0, exp_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: whole elements, last flag and outcome derived from N by division
  task automatic model(input int n);
    int e, whole;
    logic [15:0] cmd;
    logic [31:0] w;
    if (n < 2) begin exp_err++; return; end
    cmd = {fb[0], fb[1]};
    if (cmd == 16'h0001) e = 4;
    else if (cmd == 16'h0002) e = 2;
    else begin exp_err++; return; end
    whole = (n - 2) / e;
    for (int i = 0; i < whole; i++) begin
      w = '0;
      for (int k = 0; k < e; k++) w = {w[23:0], fb[2 + i * e + k]};
      if (e == 4) exp_rb.push_back({(i == whole - 1), w});
      else exp_adc.push_back(w[15:0]);
    end
    if ((n - 2) % e == 0) exp_ack++;
    else exp_err++;
  endtask

  task automatic cyc(input logic ne, input logic [15:0] n, input logic be, input logic [7:0] b);
    @(negedge clk);
    num_en = ne; num = n; byte_en = be; byte_d = b;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 16'd0, 1'b0, 8'h00);
  endtask

  task automatic run_frame(input int n);
    model(n);
    cyc(1'b1, 16'(n), 1'b0, 8'h00);
    foreach (fb[i]) cyc(1'b0, 16'd0, 1'b1, fb[i]);
    idle(3);
  endtask

  task automatic settle(input string tag);
    idle(2);
    check({tag, "_rb_left"}, exp_rb.size(), 0);
    check({tag, "_adc_left"}, exp_adc.size(), 0);
    check({tag, "_ack"}, ack_seen, exp_ack);
    check({tag, "_err"}, err_seen, exp_err);
    check({tag, "_cnt"}, err_cnt, (exp_err > 255) ? 255 : exp_err);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rb_vld) begin
        if (exp_rb.size() == 0) check("rb_unexpected", 1, 0);
        else begin
          rb_e = exp_rb.pop_front();
          check("rb_data", rb_data, rb_e[31:0]);
          check("rb_last", rb_last, rb_e[32]);
        end
      end else if (rb_last) check("rb_last_alone", 1, 0);
      if (adc_vld) begin
        if (exp_adc.size() == 0) check("adc_unexpected", 1, 0);
        else begin
          adc_e = exp_adc.pop_front();
          check("adc_data", adc_data, adc_e);
        end
      end
      if (ack) ack_seen++;
      if (err) err_seen++;
    end
  end

  initial begin
    idle(3);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_rb", {rb_vld, rb_last, rb_data}, 0);
    check("rst_adc", {adc_vld, adc_data}, 0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    fb = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04};
    run_frame(10);
    settle("readback");
    check("rb_hold", rb_data, 32'h0003_0004);

    fb = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02};
    run_frame(8);
    settle("adc");
    check("adc_hold", adc_data, 16'h0002);

    fb = '{8'h00, 8'h01};
    run_frame(2);
    settle("empty");

    fb = '{8'h00};
    run_frame(1);
    settle("n1");
    check("n1_cnt_is_1", err_cnt, 1);

    fb = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    run_frame(7);
    settle("n7");

    fb = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(6);
    settle("unknown");

    // Abort a readback frame after 3 payload bytes with an ADC frame
    cyc(1'b1, 16'd10, 1'b0, 8'h00);
    cyc(1'b0, 16'd0, 1'b1, 8'h00);
    cyc(1'b0, 16'd0, 1'b1, 8'h01);
    cyc(1'b0, 16'd0, 1'b1, 8'h11);
    cyc(1'b0, 16'd0, 1'b1, 8'h22);
    cyc(1'b0, 16'd0, 1'b1, 8'h33);
    exp_err++;
    fb = '{8'h00, 8'h02, 8'hAB, 8'hCD};
    run_frame(4);
    settle("abort");

    // Stray byte in IDLE, then frame start with a coincident byte that must be dropped
    cyc(1'b0, 16'd0, 1'b1, 8'h77);
    idle(1);
    exp_adc.push_back(16'h1234);
    exp_ack++;
    cyc(1'b1, 16'd4, 1'b1, 8'h55);
    cyc(1'b0, 16'd0, 1'b1, 8'h00);
    cyc(1'b0, 16'd0, 1'b1, 8'h02);
    cyc(1'b0, 16'd0, 1'b1, 8'h12);
    cyc(1'b0, 16'd0, 1'b1, 8'h34);
    idle(3);
    settle("stray");

    // Mid-payload stall of 20 cycles
    fb = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef FRAME_TIMEOUT_EN
    exp_err++;
    cyc(1'b1, 16'd10, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b1, fb[i]);
    idle(20);
    settle("timeout");
    run_frame(10);
    settle("after_timeout");
`else
    model(10);
    cyc(1'b1, 16'd10, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'd0, 1'b1, fb[i]);
    idle(20);
    for (int i = 4; i < 10; i++) cyc(1'b0, 16'd0, 1'b1, fb[i]);
    idle(3);
    settle("stall");
`endif

    // Saturate the error counter with back-to-back short frames
    for (int i = 0; i < 260; i++) cyc(1'b1, 16'd0, 1'b0, 8'h00);
    exp_err += 260;
    idle(3);
    settle("saturate");
    check("sat_cnt_255", err_cnt, 8'hFF);

    // Reset in the middle of a frame discards everything
    cyc(1'b1, 16'd10, 1'b0, 8'h00);
    cyc(1'b0, 16'd0, 1'b1, 8'h00);
    cyc(1'b0, 16'd0, 1'b1, 8'h01);
    cyc(1'b0, 16'd0, 1'b1, 8'h11);
    @(negedge clk); rst = 1'b1; byte_en = 1'b0;
    idle(2);
    ack_seen = 0; err_seen = 0; exp_ack = 0; exp_err = 0;
    check("mid_rst_cnt", err_cnt, 0);
    check("mid_rst_rb", rb_data, 0);
    @(negedge clk); rst = 1'b0;
    fb = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    run_frame(6);
    settle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
